// File: rtl/h4_secded_decode_pipe.sv
// Two-stage extended-Hamming (SECDED) decoder with valid/ready flow control
// and saturating single/double error counters for slow-control readout.
module h4_secded_decode_pipe #(
    parameter int unsigned R     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2**R-1:0]       in_code_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2**R-1:0]       out_code_o,
    output logic [2**R-R-2:0]     out_data_o,
    output logic                  out_sec_o,
    output logic                  out_ded_o,
    output logic [R-1:0]          out_syndrome_o,
    input  logic                  cnt_clr_i,
    output logic [CNT_W-1:0]      sec_cnt_o,
    output logic [CNT_W-1:0]      ded_cnt_o
);

    localparam int unsigned N = 2**R;
    localparam int unsigned K = N - 1 - R;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Positions contributing to syndrome bit b: every index 1..N-1 with bit b set.
    function automatic logic [N-1:0] syn_mask(input int unsigned b);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if (((i >> b) & 32'd1) != 32'd0) begin
                m = m | (N'(1) << i);
            end
        end
        return m;
    endfunction

    // Codeword position of information bit k (k-th non-power-of-2 index from 3 up).
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 3;
        for (int unsigned i = 3; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) begin
                    pos = i;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    logic           s2_can_load;
    logic           s1_valid;
    logic [N-1:0]   s1_code;
    logic [R-1:0]   s1_syn;
    logic           s1_par;

    logic [R-1:0]   in_syn;
    logic           in_par;

    logic           corr_sec;
    logic           corr_ded;
    logic [N-1:0]   corr_code;
    logic [K-1:0]   corr_data;

    logic           deliver;
    logic           sec_evt;
    logic           ded_evt;

    // Handshake: each stage advances when its successor is empty or draining.
    assign s2_can_load = !out_valid_o || out_ready_i;
    assign in_ready_o  = !s1_valid || s2_can_load;

    for (genvar b = 0; b < R; b++) begin : g_syn
        localparam logic [N-1:0] MASK = syn_mask(b);
        assign in_syn[b] = ^(in_code_i & MASK);
    end
    assign in_par = ^in_code_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            s1_code <= in_code_i;
            s1_syn  <= in_syn;
            s1_par  <= in_par;
        end
    end

    // Odd overall parity means one error; a zero syndrome then points at bit 0.
    always_comb begin
        corr_sec  = s1_par;
        corr_ded  = !s1_par && (s1_syn != '0);
        corr_code = s1_code;
        if (corr_sec) begin
            corr_code = s1_code ^ (N'(1) << s1_syn);
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_data
        localparam int unsigned POS = data_pos(k);
        assign corr_data[k] = corr_code[POS];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
        end else if (s2_can_load) begin
            out_valid_o <= s1_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (s2_can_load && s1_valid) begin
            out_code_o     <= corr_code;
            out_data_o     <= corr_data;
            out_sec_o      <= corr_sec;
            out_ded_o      <= corr_ded;
            out_syndrome_o <= s1_syn;
        end
    end

    assign deliver = out_valid_o && out_ready_i;
    assign sec_evt = deliver && out_sec_o;
    assign ded_evt = deliver && out_ded_o;

    // Counters count delivered words; a coincident clear keeps the current event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_cnt_o <= '0;
            ded_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            sec_cnt_o <= CNT_W'(sec_evt);
            ded_cnt_o <= CNT_W'(ded_evt);
        end else begin
            if (sec_evt && (sec_cnt_o != CNT_MAX)) begin
                sec_cnt_o <= sec_cnt_o + CNT_W'(1);
            end
            if (ded_evt && (ded_cnt_o != CNT_MAX)) begin
                ded_cnt_o <= ded_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_h4_secded_decode_pipe.sv
// Bench for h4_secded_decode_pipe (R=4, CNT_W=2): hand-computed vector table,
// scoreboard queue, backpressure stream, counter saturation/clear and mid-stream reset.
module tb_h4_secded_decode_pipe;

    localparam int unsigned R     = 4;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [15:0] code;
        logic [10:0] data;
        logic        sec;
        logic        ded;
        logic [3:0]  syn;
    } exp_t;

    typedef struct {
        logic [15:0] in;
        exp_t        e;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_code_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_code_o;
    logic [10:0] out_data_o;
    logic        out_sec_o;
    logic        out_ded_o;
    logic [3:0]  out_syndrome_o;
    logic        cnt_clr_i;
    logic [1:0]  sec_cnt_o;
    logic [1:0]  ded_cnt_o;

    h4_secded_decode_pipe #(.R(R), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_code_i      (in_code_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_code_o     (out_code_o),
        .out_data_o     (out_data_o),
        .out_sec_o      (out_sec_o),
        .out_ded_o      (out_ded_o),
        .out_syndrome_o (out_syndrome_o),
        .cnt_clr_i      (cnt_clr_i),
        .sec_cnt_o      (sec_cnt_o),
        .ded_cnt_o      (ded_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] m_sec;
    logic [1:0] m_ded;
    logic       prev_stall;
    exp_t       prev_out;
    logic       saw_block;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] c, input logic [10:0] d,
                                input logic s, input logic de, input logic [3:0] y);
        exp_t e;
        e.code = c;
        e.data = d;
        e.sec  = s;
        e.ded  = de;
        e.syn  = y;
        return e;
    endfunction

    // Reference decoder for random stream words.
    function automatic exp_t model(input logic [15:0] c);
        exp_t       e;
        logic [3:0] s;
        logic       p;
        int         j;
        s = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (c[i[3:0]]) s = s ^ 4'(i);
        end
        p = ^c;
        e.code = c;
        e.sec  = 1'b0;
        e.ded  = 1'b0;
        e.syn  = s;
        e.data = '0;
        if (p) begin
            e.sec = 1'b1;
            e.code[s] = ~e.code[s];
        end else if (s != 4'd0) begin
            e.ded = 1'b1;
        end
        j = 0;
        for (int i = 3; i < 16; i++) begin
            if ($countones(i) != 1) begin
                e.data[j[3:0]] = e.code[i[3:0]];
                j++;
            end
        end
        return e;
    endfunction

    function automatic exp_t got();
        return {out_code_o, out_data_o, out_sec_o, out_ded_o, out_syndrome_o};
    endfunction

    // One clock: drive, check outputs/handshakes, advance to edge+1.
    task automatic cycle(input logic v, input logic [15:0] c, input exp_t e, input logic ordy,
                         input logic clr, input logic rst, output logic acc);
        exp_t cur;
        exp_t x;
        logic dlv;
        logic sev;
        logic dev;
        in_valid_i  = v;
        in_code_i   = c;
        out_ready_i = ordy;
        cnt_clr_i   = clr;
        rst_i       = rst;
        acc         = 1'b0;
        #1;
        check("sec_cnt", 64'(sec_cnt_o), 64'(m_sec));
        check("ded_cnt", 64'(ded_cnt_o), 64'(m_ded));
        cur = got();
        if (prev_stall) check("stall_hold", 64'({out_valid_o, cur}), 64'({1'b1, prev_out}));
        if (!in_ready_o) saw_block = 1'b1;
        dlv = out_valid_o && out_ready_i;
        sev = 1'b0;
        dev = 1'b0;
        if (dlv) begin
            if (q.size() == 0) begin
                check("stray_output", 64'(out_valid_o), 64'(0));
            end else begin
                x = q.pop_front();
                check("deliver", 64'(cur), 64'(x));
                sev = x.sec;
                dev = x.ded;
            end
        end
        if (clr) begin
            m_sec = sev ? 2'd1 : 2'd0;
            m_ded = dev ? 2'd1 : 2'd0;
        end else begin
            if (sev && m_sec != 2'b11) m_sec = m_sec + 2'd1;
            if (dev && m_ded != 2'b11) m_ded = m_ded + 2'd1;
        end
        if (v && in_ready_o && !rst) begin
            q.push_back(e);
            acc = 1'b1;
        end
        prev_stall = out_valid_o && !ordy;
        prev_out   = cur;
        @(posedge clk_i);
        #1;
        if (rst) begin
            q.delete();
            m_sec      = 2'd0;
            m_ded      = 2'd0;
            prev_stall = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 16'h0, '0, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [15:0] c, input exp_t e);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, c, e, 1'b1, 1'b0, 1'b0, acc);
        if (!acc) check("accept_timeout", 64'(in_ready_o), 64'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) idle(1'b1);
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic        acc;
        logic        clr_now;
        int          sent;
        int          pos;
        logic [15:0] c;

        tbl[0] = '{16'h0000, mk(16'h0000, 11'h000, 1'b0, 1'b0, 4'h0)};
        tbl[1] = '{16'h0020, mk(16'h0000, 11'h000, 1'b1, 1'b0, 4'h5)};
        tbl[2] = '{16'h0048, mk(16'h0048, 11'h005, 1'b0, 1'b1, 4'h5)};
        tbl[3] = '{16'h0001, mk(16'h0000, 11'h000, 1'b1, 1'b0, 4'h0)};
        tbl[4] = '{16'h000F, mk(16'h000F, 11'h001, 1'b0, 1'b0, 4'h0)};
        tbl[5] = '{16'h0007, mk(16'h000F, 11'h001, 1'b1, 1'b0, 4'h3)};
        tbl[6] = '{16'hFFFF, mk(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'h0)};
        tbl[7] = '{16'h7FFF, mk(16'hFFFF, 11'h7FF, 1'b1, 1'b0, 4'hF)};
        tbl[8] = '{16'h8001, mk(16'h8001, 11'h400, 1'b0, 1'b1, 4'hF)};
        tbl[9] = '{16'h0003, mk(16'h0003, 11'h000, 1'b0, 1'b1, 4'h1)};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_code_i   = 16'h0;
        out_ready_i = 1'b1;
        cnt_clr_i   = 1'b0;
        saw_block   = 1'b0;
        prev_stall  = 1'b0;
        prev_out    = '0;
        m_sec       = 2'd0;
        m_ded       = 2'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_sec_cnt", 64'(sec_cnt_o), 64'(0));
        check("rst_ded_cnt", 64'(ded_cnt_o), 64'(0));
        idle(1'b1);
        check("rst_in_ready", 64'(in_ready_o), 64'(1));

        // Two-cycle latency on the first word.
        send(tbl[0].in, tbl[0].e);
        check("lat_cycle1", 64'(out_valid_o), 64'(0));
        idle(1'b1);
        check("lat_cycle2", 64'(out_valid_o), 64'(1));

        for (int i = 1; i < 10; i++) send(tbl[i].in, tbl[i].e);
        drain();

        // Backpressure stream: consumer stalls during stream cycles 3..6.
        saw_block = 1'b0;
        sent = 0;
        for (int t = 0; t < 60 && (sent < 8 || q.size() != 0); t++) begin
            c = 16'($urandom());
            cycle(sent < 8, c, model(c), !(t >= 3 && t <= 6), 1'b0, 1'b0, acc);
            if (acc) sent++;
        end
        check("stream_sent", 64'(sent), 64'(8));
        check("stream_drained", 64'(q.size()), 64'(0));
        check("stream_in_ready_low", 64'(saw_block), 64'(1));

        // Counter saturation at 3, then clear coincident with a SEC delivery.
        cycle(1'b0, 16'h0, '0, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            pos = int'($urandom_range(1, 15));
            send(16'(1) << pos, mk(16'h0000, 11'h000, 1'b1, 1'b0, 4'(pos)));
        end
        drain();
        check("sec_saturate", 64'(sec_cnt_o), 64'(3));
        send(16'h0400, mk(16'h0000, 11'h000, 1'b1, 1'b0, 4'hA));
        for (int k = 0; k < 10; k++) begin
            clr_now = out_valid_o;
            cycle(1'b0, 16'h0, '0, 1'b1, clr_now, 1'b0, acc);
            if (clr_now) break;
        end
        check("sec_clr_with_event", 64'(sec_cnt_o), 64'(1));
        check("ded_clr", 64'(ded_cnt_o), 64'(0));

        // Reset with two words in flight must discard both.
        send(16'h0048, mk(16'h0048, 11'h005, 1'b0, 1'b1, 4'h5));
        send(16'h0020, mk(16'h0000, 11'h000, 1'b1, 1'b0, 4'h5));
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_flush_valid", 64'(out_valid_o), 64'(0));
        check("rst_flush_sec_cnt", 64'(sec_cnt_o), 64'(0));
        for (int k = 0; k < 5; k++) begin
            idle(1'b1);
            check("rst_no_stale", 64'(out_valid_o), 64'(0));
        end
        check("post_rst_in_ready", 64'(in_ready_o), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
